icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache_pkg.sv | 25 ++
 rtl/icache_array.sv | 53 +++++
 rtl/icache.sv | 182 ++++++++++++++++++
 tb/tb_icache.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: default geometry,
// FSM state encodings and common constants.
package icache_pkg;

    localparam int unsigned ICACHE_LINE_NUM        = 16;
    localparam int unsigned ICACHE_INST_BLOCK_SIZE = 128;

    localparam logic        TRUE  = 1'b1;
    localparam logic        FALSE = 1'b0;
    localparam logic [31:0] NULL  = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMiss = 2'd1,
        StWait = 2'd2,
        StFill = 2'd3
    } state_e;

    // Clear the byte-offset bits so the address points at the start of a line.
    function automatic logic [31:0] block_align(input logic [31:0] addr,
                                                input int unsigned off_bits);
        return addr & ~((32'h1 << off_bits) - 32'h1);
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the instruction cache: one combinational read port,
// one synchronous write port. Only the valid bits are reset.
module icache_array
    import icache_pkg::*;
#(
    parameter int unsigned LINE_NUM   = ICACHE_LINE_NUM,
    parameter int unsigned BLOCK_BITS = ICACHE_INST_BLOCK_SIZE,
    parameter int unsigned TAG_BITS   = 24,
    parameter int unsigned IDX_BITS   = $clog2(LINE_NUM)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [IDX_BITS-1:0]   rd_idx_i,
    output logic                  rd_valid_o,
    output logic [TAG_BITS-1:0]   rd_tag_o,
    output logic [BLOCK_BITS-1:0] rd_data_o,
    input  logic                  we_i,
    input  logic [IDX_BITS-1:0]   wr_idx_i,
    input  logic [TAG_BITS-1:0]   wr_tag_i,
    input  logic [BLOCK_BITS-1:0] wr_data_i
);

    logic [LINE_NUM-1:0]   valid_q, valid_d;
    logic [TAG_BITS-1:0]   tag_q  [LINE_NUM];
    logic [BLOCK_BITS-1:0] data_q [LINE_NUM];

    always_comb begin
        valid_d = valid_q;
        if (we_i) begin
            valid_d[wr_idx_i] = TRUE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache with a single outstanding refill.
// Optional ICACHE_PERF_EN adds saturating hit_count/miss_count output counters.
module icache
    import icache_pkg::*;
#(
    parameter int unsigned LINE_NUM   = ICACHE_LINE_NUM,
    parameter int unsigned BLOCK_BITS = ICACHE_INST_BLOCK_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  req_valid_from_fch,
    input  logic [31:0]           pc_from_fch,
    input  logic                  rollback_sign_from_fch,
    output logic                  ready_to_fch,
    output logic                  inst_valid_to_fch,
    output logic [31:0]           inst_to_fch,
    output logic [31:0]           inst_pc_to_fch,
    output logic                  enable_sign_to_mem,
    output logic [31:0]           pc_to_mem,
    input  logic                  finish_sign_from_mem,
`ifdef ICACHE_PERF_EN
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count,
`endif
    input  logic [BLOCK_BITS-1:0] inst_block_from_mem
);

    // Line geometry; BLOCK_BITS must hold at least two 32-bit words.
    localparam int unsigned OFF_BITS  = $clog2(BLOCK_BITS / 8);
    localparam int unsigned IDX_BITS  = $clog2(LINE_NUM);
    localparam int unsigned TAG_BITS  = 32 - OFF_BITS - IDX_BITS;
    localparam int unsigned WORD_BITS = OFF_BITS - 2;
    localparam int unsigned WORD_NUM  = BLOCK_BITS / 32;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_inst_q, resp_inst_d;
    logic [31:0] resp_pc_q, resp_pc_d;

    logic [31:0]                  look_pc;
    logic [IDX_BITS-1:0]          look_idx;
    logic [TAG_BITS-1:0]          look_tag;
    logic [WORD_BITS-1:0]         look_word;
    logic                         rd_valid;
    logic [TAG_BITS-1:0]          rd_tag;
    logic [BLOCK_BITS-1:0]        rd_data;
    logic [WORD_NUM-1:0][31:0]    rd_words;
    logic [31:0]                  sel_inst;
    logic                         hit;
    logic                         accept;
    logic                         refill_we;
    logic                         unused_pc_bits;

    // The refill line is read back in FILL; otherwise the lookup uses the live request.
    assign look_pc   = (state_q == StFill) ? pc_q : pc_from_fch;
    assign look_idx  = look_pc[OFF_BITS +: IDX_BITS];
    assign look_tag  = look_pc[31 -: TAG_BITS];
    assign look_word = look_pc[2 +: WORD_BITS];
    assign unused_pc_bits = ^look_pc[1:0];

    assign rd_words = rd_data;
    assign sel_inst = rd_words[look_word];
    assign hit      = rd_valid && (rd_tag == look_tag);

    assign ready_to_fch       = (state_q == StIdle) && !rollback_sign_from_fch;
    assign accept             = rdy && req_valid_from_fch && ready_to_fch;
    assign refill_we          = rdy && (state_q == StWait) && finish_sign_from_mem;
    assign enable_sign_to_mem = rdy && (state_q == StMiss) && !rollback_sign_from_fch;
    assign pc_to_mem          = block_align(pc_q, OFF_BITS);

    assign inst_valid_to_fch = resp_valid_q;
    assign inst_to_fch       = resp_inst_q;
    assign inst_pc_to_fch    = resp_pc_q;

    icache_array #(
        .LINE_NUM   (LINE_NUM),
        .BLOCK_BITS (BLOCK_BITS),
        .TAG_BITS   (TAG_BITS),
        .IDX_BITS   (IDX_BITS)
    ) u_array (
        .clk_i      (clk),
        .rst_ni     (rst),
        .rd_idx_i   (look_idx),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .we_i       (refill_we),
        .wr_idx_i   (pc_q[OFF_BITS +: IDX_BITS]),
        .wr_tag_i   (pc_q[31 -: TAG_BITS]),
        .wr_data_i  (inst_block_from_mem)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        resp_valid_d = FALSE;
        resp_inst_d  = NULL;
        resp_pc_d    = NULL;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (hit) begin
                        resp_valid_d = TRUE;
                        resp_inst_d  = sel_inst;
                        resp_pc_d    = pc_from_fch;
                    end else begin
                        pc_d    = pc_from_fch;
                        state_d = StMiss;
                    end
                end
            end
            StMiss: begin
                state_d = rollback_sign_from_fch ? StIdle : StWait;
            end
            StWait: begin
                // A finish coinciding with rollback still fills the line via refill_we.
                if (rollback_sign_from_fch) begin
                    state_d = StIdle;
                end else if (finish_sign_from_mem) begin
                    state_d = StFill;
                end
            end
            StFill: begin
                state_d = StIdle;
                if (!rollback_sign_from_fch) begin
                    resp_valid_d = TRUE;
                    resp_inst_d  = sel_inst;
                    resp_pc_d    = pc_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            pc_q         <= NULL;
            resp_valid_q <= FALSE;
            resp_inst_q  <= NULL;
            resp_pc_q    <= NULL;
        end else if (rdy) begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            resp_valid_q <= resp_valid_d;
            resp_inst_q  <= resp_inst_d;
            resp_pc_q    <= resp_pc_d;
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (accept && hit && (hit_cnt_q != '1)) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if (accept && !hit && (miss_cnt_q != '1)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (rdy) begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed scoreboard bench for icache: responses are predicted from a memory
// model when requests are issued and matched as inst_valid pulses appear.
module tb_icache;

    localparam int unsigned LN = 16;
    localparam int unsigned BB = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rdy = 1'b1;
    logic          req_valid = 1'b0;
    logic [31:0]   pc_in = 32'h0;
    logic          rollback = 1'b0;
    logic          finish = 1'b0;
    logic [BB-1:0] blk = '0;

    logic          ready;
    logic          inst_valid;
    logic [31:0]   inst;
    logic [31:0]   inst_pc;
    logic          enable;
    logic [31:0]   pc_to_mem;

    int            n_assert = 0;
    int            n_fail = 0;
    int            n_enable = 0;
    int            n_valid = 0;
    logic          en_prev = 1'b0;
    logic [63:0]   exp_q[$];

    always #5 clk = ~clk;

    icache #(
        .LINE_NUM   (LN),
        .BLOCK_BITS (BB)
    ) dut (
        .clk                    (clk),
        .rst                    (rst_n),
        .rdy                    (rdy),
        .req_valid_from_fch     (req_valid),
        .pc_from_fch            (pc_in),
        .rollback_sign_from_fch (rollback),
        .ready_to_fch           (ready),
        .inst_valid_to_fch      (inst_valid),
        .inst_to_fch            (inst),
        .inst_pc_to_fch         (inst_pc),
        .enable_sign_to_mem     (enable),
        .pc_to_mem              (pc_to_mem),
        .finish_sign_from_mem   (finish),
        .inst_block_from_mem    (blk)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'h0000_1004) return 32'h0050_0093;
        return (a ^ 32'h5A5A_0000) + 32'h0000_0013;
    endfunction

    function automatic logic [BB-1:0] block_for(input logic [31:0] base);
        logic [BB-1:0] b;
        for (int k = 0; k < int'(BB / 32); k++) begin
            b[k*32 +: 32] = word_at(base + 32'(4 * k));
        end
        return b;
    endfunction

    function automatic logic [31:0] align(input logic [31:0] a);
        return a & ~32'h0000_000F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer and single-cycle enable monitor.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (enable) begin
                n_enable++;
                chk("enable_single_cycle", 32'(en_prev), 32'h0);
            end
            en_prev = enable;
            if (inst_valid) begin
                n_valid++;
                n_assert++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_valid: pc %h inst %h, none expected", inst_pc, inst);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("resp_pc", inst_pc, e[63:32]);
                    chk("resp_inst", inst, e[31:0]);
                end
            end
        end
    end

    task automatic req(input logic [31:0] a, input bit push);
        req_valid = 1'b1;
        pc_in = a;
        @(negedge clk);
        chk("ready_on_req", 32'(ready), 32'h1);
        if (push) exp_q.push_back({a, word_at(a)});
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_enable(input logic [31:0] exp_addr);
        bit seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (enable) seen = 1'b1;
        end
        chk("enable_seen", 32'(seen), 32'h1);
        if (seen) chk("pc_to_mem", pc_to_mem, exp_addr);
        @(posedge clk);
        #1;
    endtask

    task automatic finish_pulse(input logic [31:0] base);
        finish = 1'b1;
        blk = block_for(base);
        @(posedge clk);
        #1 finish = 1'b0;
    endtask

    task automatic wait_valid();
        bit seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (inst_valid) seen = 1'b1;
        end
        chk("refill_response", 32'(seen), 32'h1);
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input int n);
        int v0 = n_valid;
        int e0 = n_enable;
        repeat (n) @(posedge clk);
        #1;
        chk("quiet_no_valid", 32'(n_valid), 32'(v0));
        chk("quiet_no_enable", 32'(n_enable), 32'(e0));
    endtask

    task automatic expect_hit(input logic [31:0] a);
        int e0 = n_enable;
        req(a, 1'b1);
        @(negedge clk);
        chk("hit_next_cycle", 32'(inst_valid), 32'h1);
        chk("hit_no_enable", 32'(n_enable), 32'(e0));
        @(posedge clk);
        #1;
    endtask

    task automatic expect_miss(input logic [31:0] a);
        req(a, 1'b1);
        wait_enable(align(a));
        finish_pulse(align(a));
        wait_valid();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_inst_valid", 32'(inst_valid), 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_enable", 32'(enable), 32'h0);
        chk("rst_pc_to_mem", pc_to_mem, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(ready), 32'h1);
        @(posedge clk);
        #1;

        // Cold miss, then hits in the same line.
        expect_miss(32'h0000_1004);
        expect_hit(32'h0000_1008);

        // Conflict eviction on index 0.
        expect_hit(32'h0000_1000);
        expect_miss(32'h0000_1100);
        expect_miss(32'h0000_1000);

        // Back-to-back hits, one per cycle.
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pc_in = 32'h0000_1000 + 32'(4 * i);
            @(negedge clk);
            chk("burst_ready", 32'(ready), 32'h1);
            exp_q.push_back({pc_in, word_at(pc_in)});
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("burst_drained", 32'(exp_q.size()), 32'h0);

        // Rollback in WAIT, stray finish two cycles later.
        req(32'h0000_2000, 1'b0);
        wait_enable(32'h0000_2000);
        rollback = 1'b1;
        @(negedge clk);
        chk("ready_low_rollback", 32'(ready), 32'h0);
        @(posedge clk);
        #1 rollback = 1'b0;
        @(posedge clk);
        #1;
        finish_pulse(32'h0000_2000);
        quiet(3);
        expect_miss(32'h0000_2000);

        // Rollback and finish together in WAIT: line still written.
        req(32'h0000_3000, 1'b0);
        wait_enable(32'h0000_3000);
        rollback = 1'b1;
        finish = 1'b1;
        blk = block_for(32'h0000_3000);
        @(posedge clk);
        #1;
        rollback = 1'b0;
        finish = 1'b0;
        quiet(3);
        expect_hit(32'h0000_3004);

        // Rollback in MISS: no refill request.
        req(32'h0000_4000, 1'b0);
        rollback = 1'b1;
        @(negedge clk);
        chk("miss_rollback_no_enable", 32'(enable), 32'h0);
        @(posedge clk);
        #1 rollback = 1'b0;
        quiet(3);
        @(negedge clk);
        chk("idle_after_miss_rollback", 32'(ready), 32'h1);
        @(posedge clk);
        #1;

        // Request with simultaneous rollback is refused.
        req_valid = 1'b1;
        rollback = 1'b1;
        pc_in = 32'h0000_1008;
        @(negedge clk);
        chk("req_rollback_refused", 32'(ready), 32'h0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rollback = 1'b0;
        quiet(2);

        // Freeze with rdy low during WAIT while finish is held.
        req(32'h0000_5000, 1'b1);
        wait_enable(32'h0000_5000);
        rdy = 1'b0;
        finish = 1'b1;
        blk = block_for(32'h0000_5000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("freeze_no_valid", 32'(inst_valid), 32'h0);
            chk("freeze_not_ready", 32'(ready), 32'h0);
            @(posedge clk);
            #1;
        end
        rdy = 1'b1;
        @(posedge clk);
        #1 finish = 1'b0;
        wait_valid();

        // Reset mid-refill clears valid bits; late finish ignored.
        req(32'h0000_6000, 1'b0);
        wait_enable(32'h0000_6000);
        rst_n = 1'b0;
        #1;
        chk("midrst_inst_valid", 32'(inst_valid), 32'h0);
        chk("midrst_inst", inst, 32'h0);
        chk("midrst_inst_pc", inst_pc, 32'h0);
        chk("midrst_enable", 32'(enable), 32'h0);
        chk("midrst_pc_to_mem", pc_to_mem, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        finish_pulse(32'h0000_6000);
        quiet(3);
        expect_miss(32'h0000_1008);

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
